// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the CPU-side byte-bus memory controller.
//   ADDR_WIDTH    : width of every byte address on both the CPU and bus sides
//   SIZE_*        : load/store size encodings as presented on ls_size_in
//   state_t       : controller FSM states
//   src_t         : which requester owns the operation in flight
//   size_to_bytes : byte count N for a load/store size code (3 behaves as word)
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_t;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      SIZE_W:  n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and byte-bus signals of the memory controller.
//   if_*  : instruction-fetch request (level req, one-cycle done pulse + word)
//   ls_*  : load/store request (level req, write flag, size, store data,
//           one-cycle done pulse + zero-extended load data)
//   mem_* : byte-wide system bus (address, write byte, write strobe, read byte)
// Modports:
//   slave  : the controller (consumes requests, drives the bus)
//   master : the CPU core plus memory side (issues requests, returns read bytes)
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                  if_req_in;
  logic [ADDR_WIDTH-1:0] if_addr_in;
  logic                  if_done_out;
  logic [31:0]           if_data_out;

  logic                  ls_req_in;
  logic                  ls_wr_in;
  logic [1:0]            ls_size_in;
  logic [ADDR_WIDTH-1:0] ls_addr_in;
  logic [31:0]           ls_wdata_in;
  logic                  ls_done_out;
  logic [31:0]           ls_rdata_out;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport slave (
    input  if_req_in, if_addr_in,
    input  ls_req_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in,
    input  mem_din,
    output if_done_out, if_data_out,
    output ls_done_out, ls_rdata_out,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req_in, if_addr_in,
    output ls_req_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in,
    output mem_din,
    input  if_done_out, if_data_out,
    input  ls_done_out, ls_rdata_out,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetches and load/stores (load/store first)
// and serialises each into little-endian byte accesses on the 8-bit bus.
// Reads honour the RAM's one-cycle synchronous latency; everything freezes
// while rdy_in is low (bus handed to the debug interface).
// Ports:
//   clk_in   : system clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   rdy_in   : 1 = bus owned by the CPU, 0 = paused
//   bus      : mem_ctrl_if.slave (request/response and byte-bus signals)
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  mem_ctrl_if.slave  bus
);

  state_t                state_r, state_nx_s;
  src_t                  src_r, src_nx_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nx_s;
  logic [2:0]            n_r, n_nx_s;
  logic [31:0]           wdata_r, wdata_nx_s;
  logic [31:0]           data_r, data_nx_s;
  // iss: index of the byte whose address sits on mem_a
  // cap: index of the next byte lane to fill from mem_din
  logic [2:0]            iss_r, iss_nx_s;
  logic [2:0]            cap_r, cap_nx_s;
  // a_vld: mem_a holds a read address the RAM samples at the next edge
  // d_vld: mem_din carries the byte destined for lane cap this cycle
  logic                  a_vld_r, a_vld_nx_s;
  logic                  d_vld_r, d_vld_nx_s;

  logic [ADDR_WIDTH-1:0] mem_a_r, mem_a_nx_s;
  logic [7:0]            mem_dout_r, mem_dout_nx_s;
  logic                  mem_wr_r, mem_wr_nx_s;
  logic                  if_done_r, if_done_nx_s;
  logic [31:0]           if_data_r, if_data_nx_s;
  logic                  ls_done_r, ls_done_nx_s;
  logic [31:0]           ls_rdata_r, ls_rdata_nx_s;

  logic                  req_any_s;
  logic                  pick_ls_s;
  logic                  sel_wr_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [2:0]            sel_n_s;
  logic [2:0]            iss_inc_s;
  logic                  last_issue_s;
  logic                  last_cap_s;

  // Byte k lives at base+k; wraps modulo 2^ADDR_WIDTH, no alignment check.
  function automatic logic [ADDR_WIDTH-1:0] byte_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [2:0]            idx
  );
    return base + {{(ADDR_WIDTH-3){1'b0}}, idx};
  endfunction

  // Request selection: load/store has priority over fetch.
  always_comb begin
    req_any_s    = bus.ls_req_in | bus.if_req_in;
    pick_ls_s    = bus.ls_req_in;
    sel_wr_s     = bus.ls_req_in & bus.ls_wr_in;
    sel_addr_s   = pick_ls_s ? bus.ls_addr_in : bus.if_addr_in;
    sel_n_s      = pick_ls_s ? size_to_bytes(bus.ls_size_in) : 3'd4;
    iss_inc_s    = iss_r + 3'd1;
    last_issue_s = (iss_inc_s == n_r);
    last_cap_s   = ((cap_r + 3'd1) == n_r);
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; DONE always returns to IDLE so its pulse is one cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (rdy_in && req_any_s) begin
          if (sel_wr_s) begin
            state_nx_s = WRITE;
          end else begin
            state_nx_s = READ;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      READ: begin
        if (rdy_in && d_vld_r && last_cap_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = READ;
        end
      end
      WRITE: begin
        if (rdy_in && last_issue_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WRITE;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output/datapath next values; registered below.
  always_comb begin
    src_nx_s      = src_r;
    addr_nx_s     = addr_r;
    n_nx_s        = n_r;
    wdata_nx_s    = wdata_r;
    data_nx_s     = data_r;
    iss_nx_s      = iss_r;
    cap_nx_s      = cap_r;
    a_vld_nx_s    = a_vld_r;
    d_vld_nx_s    = d_vld_r;
    mem_a_nx_s    = mem_a_r;
    mem_dout_nx_s = mem_dout_r;
    mem_wr_nx_s   = mem_wr_r;
    if_done_nx_s  = 1'b0;
    if_data_nx_s  = if_data_r;
    ls_done_nx_s  = 1'b0;
    ls_rdata_nx_s = ls_rdata_r;
    case (state_r)
      IDLE: begin
        if (rdy_in && req_any_s) begin
          src_nx_s   = pick_ls_s ? SRC_LS : SRC_IF;
          addr_nx_s  = sel_addr_s;
          n_nx_s     = sel_n_s;
          wdata_nx_s = bus.ls_wdata_in;
          data_nx_s  = 32'd0;
          iss_nx_s   = 3'd0;
          cap_nx_s   = 3'd0;
          mem_a_nx_s = sel_addr_s;
          a_vld_nx_s = ~sel_wr_s;
          d_vld_nx_s = 1'b0;
          mem_wr_nx_s = sel_wr_s;
          if (sel_wr_s) begin
            mem_dout_nx_s = bus.ls_wdata_in[7:0];
          end else begin
            mem_dout_nx_s = mem_dout_r;
          end
        end else begin
          mem_wr_nx_s = 1'b0;
        end
      end
      READ: begin
        if (rdy_in) begin
          if (d_vld_r) begin
            data_nx_s[{cap_r[1:0], 3'b000} +: 8] = bus.mem_din;
            cap_nx_s = cap_r + 3'd1;
            if (last_cap_s) begin
              if (src_r == SRC_IF) begin
                if_done_nx_s = 1'b1;
                if_data_nx_s = data_nx_s;
              end else begin
                ls_done_nx_s  = 1'b1;
                ls_rdata_nx_s = data_nx_s;
              end
            end else begin
              cap_nx_s = cap_r + 3'd1;
            end
          end else begin
            cap_nx_s = cap_r;
          end
          // The address presented now returns data one cycle later.
          d_vld_nx_s = a_vld_r;
          if (a_vld_r && !last_issue_s) begin
            iss_nx_s   = iss_inc_s;
            mem_a_nx_s = byte_addr(addr_r, iss_inc_s);
            a_vld_nx_s = 1'b1;
          end else begin
            a_vld_nx_s = 1'b0;
          end
        end else begin
          // Paused: any in-flight byte is lost, so re-present the first
          // uncaptured byte; the RAM samples it on the first ready edge.
          iss_nx_s   = cap_r;
          mem_a_nx_s = byte_addr(addr_r, cap_r);
          a_vld_nx_s = 1'b1;
          d_vld_nx_s = 1'b0;
        end
      end
      WRITE: begin
        if (rdy_in) begin
          if (last_issue_s) begin
            mem_wr_nx_s  = 1'b0;
            ls_done_nx_s = 1'b1;
          end else begin
            iss_nx_s      = iss_inc_s;
            mem_a_nx_s    = byte_addr(addr_r, iss_inc_s);
            mem_dout_nx_s = wdata_r[{iss_inc_s[1:0], 3'b000} +: 8];
          end
        end else begin
          mem_wr_nx_s = mem_wr_r;
        end
      end
      DONE:    mem_wr_nx_s = 1'b0;
      default: mem_wr_nx_s = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      src_r      <= SRC_IF;
      addr_r     <= '0;
      n_r        <= 3'd0;
      wdata_r    <= 32'd0;
      data_r     <= 32'd0;
      iss_r      <= 3'd0;
      cap_r      <= 3'd0;
      a_vld_r    <= 1'b0;
      d_vld_r    <= 1'b0;
      mem_a_r    <= '0;
      mem_dout_r <= 8'd0;
      mem_wr_r   <= 1'b0;
      if_done_r  <= 1'b0;
      if_data_r  <= 32'd0;
      ls_done_r  <= 1'b0;
      ls_rdata_r <= 32'd0;
    end else begin
      src_r      <= src_nx_s;
      addr_r     <= addr_nx_s;
      n_r        <= n_nx_s;
      wdata_r    <= wdata_nx_s;
      data_r     <= data_nx_s;
      iss_r      <= iss_nx_s;
      cap_r      <= cap_nx_s;
      a_vld_r    <= a_vld_nx_s;
      d_vld_r    <= d_vld_nx_s;
      mem_a_r    <= mem_a_nx_s;
      mem_dout_r <= mem_dout_nx_s;
      mem_wr_r   <= mem_wr_nx_s;
      if_done_r  <= if_done_nx_s;
      if_data_r  <= if_data_nx_s;
      ls_done_r  <= ls_done_nx_s;
      ls_rdata_r <= ls_rdata_nx_s;
    end
  end

  assign bus.mem_a        = mem_a_r;
  assign bus.mem_dout     = mem_dout_r;
  assign bus.mem_wr       = mem_wr_r;
  assign bus.if_done_out  = if_done_r;
  assign bus.if_data_out  = if_data_r;
  assign bus.ls_done_out  = ls_done_r;
  assign bus.ls_rdata_out = ls_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte RAM model of one-cycle
// read latency; the RAM returns junk while the bus is handed away (rdy low).
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:262143];
  logic [7:0] ram_q = 8'h00;
  int         wr_count = 0;
  int         checks = 0;
  int         errors = 0;

  // RAM model: synchronous read, writes only while the CPU owns the bus.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr) begin
        ram[bus.mem_a[17:0]] <= bus.mem_dout;
        wr_count <= wr_count + 1;
      end
      ram_q <= ram[bus.mem_a[17:0]];
    end else begin
      ram_q <= 8'hA5;
    end
  end

  assign bus.mem_din = ram_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int   first_done;
  int   dones;
  int   wc0;
  logic reissued;
  logic [31:0] got;

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.if_req_in   = 1'b0;
    bus.if_addr_in  = 32'd0;
    bus.ls_req_in   = 1'b0;
    bus.ls_wr_in    = 1'b0;
    bus.ls_size_in  = 2'd0;
    bus.ls_addr_in  = 32'd0;
    bus.ls_wdata_in = 32'd0;
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05; ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h00;
    ram[18'h00104] = 8'h93; ram[18'h00105] = 8'h00; ram[18'h00106] = 8'h10; ram[18'h00107] = 8'h00;
    ram[18'h00200] = 8'h11; ram[18'h00201] = 8'h22; ram[18'h00202] = 8'h33; ram[18'h00203] = 8'h44;
    ram[18'h00300] = 8'hDE; ram[18'h00301] = 8'hAD; ram[18'h00302] = 8'hBE; ram[18'h00303] = 8'hEF;
    ram[18'h00400] = 8'h00; ram[18'h00401] = 8'h00; ram[18'h00402] = 8'h00; ram[18'h00403] = 8'h00;
    ram[18'h00500] = 8'h00; ram[18'h20001] = 8'h77;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_ctl", {20'd0, bus.mem_dout, 1'b0, bus.mem_wr, bus.if_done_out, bus.ls_done_out}, 32'd0);
    check("rst_if_data", bus.if_data_out, 32'd0);
    check("rst_ls_rdata", bus.ls_rdata_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word fetch from 0x100
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h100;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 3) check("fetch_addr", bus.mem_a, 32'h100 + 32'(k));
      check("fetch_done", 32'(bus.if_done_out), 32'(k == 5));
      check("fetch_wr", 32'(bus.mem_wr), 32'd0);
    end
    check("fetch_data", bus.if_data_out, 32'h00000513);
    bus.if_req_in = 1'b0;
    @(negedge clk);
    check("fetch_done_clr", 32'(bus.if_done_out), 32'd0);

    // Simultaneous load word (0x200) and fetch (0x104)
    bus.ls_req_in  = 1'b1; bus.ls_wr_in = 1'b0; bus.ls_size_in = SIZE_W; bus.ls_addr_in = 32'h200;
    bus.if_req_in  = 1'b1; bus.if_addr_in = 32'h104;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) check("arb_ls_first", bus.mem_a, 32'h200);
      check("arb_ls_done", 32'(bus.ls_done_out), 32'(k == 5));
      check("arb_if_done", 32'(bus.if_done_out), 32'(k == 12));
      if (k == 5) begin
        check("arb_ls_data", bus.ls_rdata_out, 32'h44332211);
        bus.ls_req_in = 1'b0;
      end
      if (k == 7) check("arb_if_accept", bus.mem_a, 32'h104);
      if (k == 12) begin
        check("arb_if_data", bus.if_data_out, 32'h00100093);
        bus.if_req_in = 1'b0;
      end
    end
    @(negedge clk);

    // Half store 0xBEEF at 0x1FFFF crossing into 0x20000
    wc0 = wr_count;
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = SIZE_H;
    bus.ls_addr_in = 32'h1FFFF; bus.ls_wdata_in = 32'h1234BEEF;
    @(negedge clk);
    check("hst_b0", {bus.mem_a[23:0], bus.mem_dout}, {24'h01FFFF, 8'hEF});
    check("hst_wr0", 32'(bus.mem_wr), 32'd1);
    @(negedge clk);
    check("hst_b1", {bus.mem_a[23:0], bus.mem_dout}, {24'h020000, 8'hBE});
    check("hst_wr1", {30'd0, bus.mem_wr, bus.ls_done_out}, 32'd2);
    @(negedge clk);
    check("hst_done", {30'd0, bus.mem_wr, bus.ls_done_out}, 32'd1);
    check("hst_rdata_hold", bus.ls_rdata_out, 32'h44332211);
    bus.ls_req_in = 1'b0;
    @(negedge clk);
    check("hst_wr_cycles", 32'(wr_count - wc0), 32'd2);
    check("hst_mem", {8'd0, ram[18'h1FFFF], ram[18'h20000], ram[18'h20001]}, 32'h00EFBE77);

    // Byte load from 0x20000
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b0; bus.ls_size_in = SIZE_B; bus.ls_addr_in = 32'h20000;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      check("bld_done", 32'(bus.ls_done_out), 32'(k == 2));
    end
    check("bld_data", bus.ls_rdata_out, 32'h000000BE);
    bus.ls_req_in = 1'b0;
    @(negedge clk);

    // Byte store 0x5A at 0x500
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = SIZE_B;
    bus.ls_addr_in = 32'h500; bus.ls_wdata_in = 32'h0000005A;
    @(negedge clk);
    check("bst_b0", {bus.mem_a[23:0], bus.mem_dout}, {24'h000500, 8'h5A});
    @(negedge clk);
    check("bst_done", {30'd0, bus.mem_wr, bus.ls_done_out}, 32'd1);
    bus.ls_req_in = 1'b0;
    @(negedge clk);
    check("bst_mem", 32'(ram[18'h00500]), 32'h5A);

    // Size code 3 behaves as word load
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b0; bus.ls_size_in = 2'd3; bus.ls_addr_in = 32'h200;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("sz3_done", 32'(bus.ls_done_out), 32'(k == 5));
    end
    check("sz3_data", bus.ls_rdata_out, 32'h44332211);
    bus.ls_req_in = 1'b0;
    @(negedge clk);

    // Word load from 0x300, paused for 3 cycles after byte 1 is captured
    first_done = -1;
    reissued   = 1'b0;
    got        = 32'd0;
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b0; bus.ls_size_in = SIZE_W; bus.ls_addr_in = 32'h300;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) rdy = 1'b0;
      if (k == 6) rdy = 1'b1;
      if (k >= 6 && rdy && bus.mem_a == 32'h302) reissued = 1'b1;
      if (bus.ls_done_out && first_done < 0) begin
        first_done = k;
        got = bus.ls_rdata_out;
        bus.ls_req_in = 1'b0;
      end
    end
    bus.ls_req_in = 1'b0;
    check("pause_latency", 32'(first_done == 8 || first_done == 9), 32'd1);
    check("pause_data", got, 32'hEFBEADDE);
    check("pause_reissue", 32'(reissued), 32'd1);
    @(negedge clk);

    // Word store to 0x400, reset during its third cycle
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = SIZE_W;
    bus.ls_addr_in = 32'h400; bus.ls_wdata_in = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    check("rstw_pre", {bus.mem_a[23:0], 7'd0, bus.mem_wr}, {24'h000402, 8'h01});
    #2 rst_n = 1'b0;
    #1;
    check("rstw_bus", {bus.mem_a[23:0], bus.mem_dout}, 32'd0);
    check("rstw_ctl", {29'd0, bus.mem_wr, bus.if_done_out, bus.ls_done_out}, 32'd0);
    check("rstw_data", bus.if_data_out | bus.ls_rdata_out, 32'd0);
    bus.ls_req_in = 1'b0;
    @(negedge clk);
    check("rstw_mem", {ram[18'h00400], ram[18'h00401], ram[18'h00402], ram[18'h00403]}, 32'h0DF00000);

    // After release: fetch held high through the done cycle
    rst_n = 1'b1;
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h100;
    dones = 0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k == 0) check("held_accept", bus.mem_a, 32'h100);
      if (k == 5) begin
        check("held_done", 32'(bus.if_done_out), 32'd1);
        check("held_data", bus.if_data_out, 32'h00000513);
      end
      if (bus.if_done_out) dones++;
      if (k == 6) bus.if_req_in = 1'b0;
    end
    check("held_one_fetch", 32'(dones), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

CPU-side memory controller sitting inside `cpu`, directly upstream of the shared byte-wide system memory bus that leads to the 128 KiB RAM and the HCI I/O window. It takes 32-bit instruction-fetch and load/store requests and arbitrates between them, load/store first. Each request is serialized into little-endian byte accesses on the 8-bit bus, honouring the RAM's one-cycle synchronous read latency. It stalls whenever the debug interface pauses the CPU.

## Interface
- `ADDR_WIDTH`, 32, width of all addresses.
- `clk_in`  in  1  system clock; all state changes on its rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  1 = bus owned by CPU; 0 = paused (bus muxed to HCI).
- `if_req_in`  in  1  fetch request, level, held until `if_done_out`.
- `if_addr_in`  in  ADDR_WIDTH  fetch address.
- `if_done_out`  out  1  one-cycle pulse; `if_data_out` valid this cycle.
- `if_data_out`  out  32  fetched word.
- `ls_req_in`  in  1  load/store request, level, held until `ls_done_out`.
- `ls_wr_in`  in  1  1 = store, 0 = load.
- `ls_size_in`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `ls_addr_in`  in  ADDR_WIDTH  access address.
- `ls_wdata_in`  in  32  store data, low bytes used.
- `ls_done_out`  out  1  one-cycle pulse on completion.
- `ls_rdata_out`  out  32  load data, zero-extended (the caller sign-extends).
- `mem_din`  in  8  read byte from the bus, valid one cycle after its address.
- `mem_dout`  out  8  write byte.
- `mem_a`  out  ADDR_WIDTH  byte address.
- `mem_wr`  out  1  1 = write this cycle.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset (async, `rst_n_in`=0): state IDLE and counters 0. All outputs are 0: `mem_a`, `mem_dout`, `mem_wr`, both done pulses and both data outputs.
- **IDLE:** if `rdy_in`=1 and a request is present, accept it.
  - `ls_req_in` wins over `if_req_in`.
  - Latch source, address, byte count N (1/2/4; fetch is always 4) and write data.
  - Load `mem_a`=addr. For a store, also drive `mem_dout`=byte0 and `mem_wr`=1.
  - Go to READ or WRITE.
- Byte k uses address addr+k, mod 2^ADDR_WIDTH. No alignment check; the address is used as given.
- **READ:**
  - Issue index `iss` steps through 0..N-1, presenting one address per ready cycle.
  - Byte returned on `mem_din` one cycle after its address is captured into lane `cap` of the data register; `cap` then increments.
  - When `cap` reaches N, go to DONE.
- **WRITE:**
  - Byte k counts as written at the end of a cycle with `mem_wr`=1 and `rdy_in`=1.
  - After the last byte is written, drop `mem_wr` and go to DONE.
- **DONE:** for exactly one cycle, assert the done pulse of the latched source and hold its data output, then return to IDLE. No request is accepted in DONE, so a requester dropping req after seeing done is never re-accepted.
- **Pause (`rdy_in`=0):**
  - Freeze state and counters.
  - Do not capture `mem_din`.
  - In READ, rewind `iss` to `cap` so the lost in-flight byte is re-issued on resume.
  - `mem_wr` may remain high; HCI owns the bus, so no write is lost or duplicated.
- Data outputs keep their last value between operations. Only the done pulses are cycle-exact.

## Timing
- Acceptance edge e0.
- **Read of N bytes, no pause:**
  - Addresses are presented on edges e0..e(N-1).
  - Byte k is captured at e(k+2).
  - DONE is entered at e(N+1), so the done pulse is visible N+1 cycles after the accepting edge.
  - Word fetch/load: 5 cycles; byte load: 2.
- **Store of N bytes:** byte k is presented from e(k); DONE is entered at e(N). Word store: 4 cycles; byte store: 1.
- **Throughput:** minimum gap between accepted requests is N+3 cycles for reads and N+2 for writes (IDLE→…→DONE→IDLE).
- Each pause cycle adds one cycle. Pausing during a read adds up to one extra re-issue cycle.

## Structure
- Shared package `mem_ctrl_pkg`:
  - size encodings (SIZE_B=0, SIZE_H=1, SIZE_W=2);
  - state enum;
  - source enum (SRC_IF, SRC_LS).
- Single module; no sub-module is warranted.

## Test plan
- **Word fetch:** `if_req_in`=1 with addr 0x100, RAM holding bytes 0x13,0x05,0x00,0x00 → `mem_a` steps 0x100..0x103; `if_done_out` pulses 5 cycles after acceptance with `if_data_out`=0x00000513.
- **Simultaneous requests:** `if_req_in` and `ls_req_in` (load word, 0x200) asserted together → load served first, `ls_done_out` pulses; fetch is accepted 2 cycles later.
- **Half store then load:** half store 0xBEEF at 0x1FFFF → bytes 0xEF at 0x1FFFF and 0xBE at 0x20000 (crossing); `mem_wr` high for exactly 2 ready cycles. A byte load from 0x20000 returns 0x000000BE.
- **Mid-read pause:** word read with `rdy_in` low for 3 cycles after the second byte is captured → the third byte's address is re-issued; the word is correct; done arrives 3-4 cycles late.
- **Reset mid-write:** `rst_n_in`=0 in the third cycle of a word store → `mem_wr`, `mem_a` and the done pulses go 0 immediately. After release the FSM is in IDLE and accepts a new fetch normally.
- **Held request:** requester keeps `if_req_in` high through the done cycle and drops it the following cycle → exactly one fetch is performed.
